// File: rtl/t_table_reader.sv
// t_table_reader: streams the T(0,i) table out of BRAM over a valid/ready port.
// Reads are issued only against free FIFO credit, so BRAM latency and downstream
// backpressure never drop or duplicate an entry.
// Optional build macro: T_READER_RESCALE_EN (saturating x4 rescale of every lane).
module t_table_reader #(
    parameter int unsigned BIT_WIDTH    = 32,
    parameter int unsigned I            = 160,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    output logic                 bram_en_out,
    output logic [$clog2(I)-1:0] bram_addr_out,
    input  logic [BIT_WIDTH-1:0] bram_data_0_in,
    input  logic [BIT_WIDTH-1:0] bram_data_1_in,
    input  logic [BIT_WIDTH-1:0] bram_data_2_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_data_0,
    output logic [BIT_WIDTH-1:0] out_data_1,
    output logic [BIT_WIDTH-1:0] out_data_2,
    output logic [$clog2(I)-1:0] out_index,
    output logic                 out_last,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam int unsigned AW         = $clog2(I);
    localparam int unsigned FIFO_DEPTH = READ_LATENCY + 2;
    localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(I - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [AW-1:0]        idx;
        logic [BIT_WIDTH-1:0] d2;
        logic [BIT_WIDTH-1:0] d1;
        logic [BIT_WIDTH-1:0] d0;
    } entry_t;

    // Optional saturating <<2 that undoes the writer's divide-by-4.
    function automatic logic [BIT_WIDTH-1:0] lane_fix(input logic [BIT_WIDTH-1:0] x);
`ifdef T_READER_RESCALE_EN
        logic [2:0] top;
        top = x[BIT_WIDTH-1 -: 3];
        if (top == 3'b000 || top == 3'b111) begin
            return {x[BIT_WIDTH-3:0], 2'b00};
        end else if (!x[BIT_WIDTH-1]) begin
            return {1'b0, {(BIT_WIDTH-1){1'b1}}};
        end else begin
            return {1'b1, {(BIT_WIDTH-1){1'b0}}};
        end
`else
        return x;
`endif
    endfunction

    state_t          state_q;
    state_t          state_d;
    logic            issue_d;
    logic [AW-1:0]   addr_d;
    logic            done_d;
    logic            has_credit;
    logic [CW-1:0]   occ_q;
    logic [CW-1:0]   occ_d;

    logic [READ_LATENCY-1:0] tag_vld_q;
    logic [AW-1:0]           tag_idx_q [READ_LATENCY];

    entry_t          fifo_q [FIFO_DEPTH];
    entry_t          fifo_d [FIFO_DEPTH];
    entry_t          wr_entry;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [CW-1:0]   cnt_after_pop;
    logic            push;
    logic            pop;

    assign push = tag_vld_q[READ_LATENCY-1];
    assign pop  = out_valid & out_ready;

    // occ counts every word issued but not yet popped (in flight or queued);
    // the decision is for next cycle's issue, so this cycle's pop frees a slot.
    assign has_credit = (occ_q - CW'(pop)) < CW'(FIFO_DEPTH);

    // Next-state, issue and completion decisions.
    always_comb begin
        state_d = state_q;
        issue_d = 1'b0;
        addr_d  = bram_addr_out;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    issue_d = 1'b1;
                    addr_d  = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (has_credit) begin
                    issue_d = 1'b1;
                    addr_d  = bram_addr_out + AW'(1);
                    if (addr_d == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && (fifo_q[0].idx == LAST_IDX)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign occ_d = occ_q + CW'(issue_d) - CW'(pop);

    // FSM state, BRAM request and status registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            occ_q         <= '0;
            bram_en_out   <= 1'b0;
            bram_addr_out <= '0;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
        end else begin
            state_q       <= state_d;
            occ_q         <= occ_d;
            bram_en_out   <= issue_d;
            bram_addr_out <= addr_d;
            busy_out      <= (state_d != ST_IDLE);
            done_out      <= done_d;
        end
    end

    // Valid/index tags that travel alongside each outstanding BRAM read.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tag_vld_q <= '0;
            for (int unsigned k = 0; k < READ_LATENCY; k++) begin
                tag_idx_q[k] <= '0;
            end
        end else begin
            tag_vld_q[0] <= bram_en_out;
            tag_idx_q[0] <= bram_addr_out;
            for (int unsigned k = 1; k < READ_LATENCY; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_idx_q[k] <= tag_idx_q[k-1];
            end
        end
    end

    // Returning word; the rescale is applied on entry so the head stays a plain register.
    always_comb begin
        wr_entry     = '0;
        wr_entry.idx = tag_idx_q[READ_LATENCY-1];
        wr_entry.d0  = lane_fix(bram_data_0_in);
        wr_entry.d1  = lane_fix(bram_data_1_in);
        wr_entry.d2  = lane_fix(bram_data_2_in);
    end

    // Shift-style FIFO: entry 0 is always the head, so outputs come straight from flops.
    always_comb begin
        fifo_d        = fifo_q;
        cnt_after_pop = cnt_q - CW'(pop);
        if (pop) begin
            for (int unsigned k = 0; k < FIFO_DEPTH - 1; k++) begin
                fifo_d[k] = fifo_q[k+1];
            end
        end
        if (push) begin
            for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
                if (cnt_after_pop == CW'(k)) begin
                    fifo_d[k] = wr_entry;
                end
            end
        end
        cnt_d = cnt_after_pop + CW'(push);
    end

    // FIFO storage plus registered valid/last flags for the head.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
                fifo_q[k] <= '0;
            end
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            fifo_q    <= fifo_d;
            cnt_q     <= cnt_d;
            out_valid <= (cnt_d != '0);
            out_last  <= (cnt_d != '0) && (fifo_d[0].idx == LAST_IDX);
        end
    end

    assign out_data_0 = fifo_q[0].d0;
    assign out_data_1 = fifo_q[0].d1;
    assign out_data_2 = fifo_q[0].d2;
    assign out_index  = fifo_q[0].idx;

    // The credit scheme must never let a returning word find the FIFO full.
    fifo_no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
        !(push && (cnt_after_pop == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_t_table_reader.sv
// tb_t_table_reader: directed bench for t_table_reader with a 2-cycle BRAM model.
module tb_t_table_reader;

    localparam int unsigned BW = 32;
    localparam int unsigned N  = 160;
    localparam int unsigned RL = 2;
    localparam int unsigned AW = $clog2(N);

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          start_in;
    logic          bram_en_out;
    logic [AW-1:0] bram_addr_out;
    logic [BW-1:0] bram_data_0_in;
    logic [BW-1:0] bram_data_1_in;
    logic [BW-1:0] bram_data_2_in;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data_0;
    logic [BW-1:0] out_data_1;
    logic [BW-1:0] out_data_2;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          busy_out;
    logic          done_out;

    int checks = 0;
    int errors = 0;

    t_table_reader #(.BIT_WIDTH(BW), .I(N), .READ_LATENCY(RL)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .bram_en_out    (bram_en_out),
        .bram_addr_out  (bram_addr_out),
        .bram_data_0_in (bram_data_0_in),
        .bram_data_1_in (bram_data_1_in),
        .bram_data_2_in (bram_data_2_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data_0     (out_data_0),
        .out_data_1     (out_data_1),
        .out_data_2     (out_data_2),
        .out_index      (out_index),
        .out_last       (out_last),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    always #5 clk_in = ~clk_in;

    // Table contents as the writer would have left them.
    function automatic logic [BW-1:0] mem_lane(input int l, input int a);
`ifdef T_READER_RESCALE_EN
        case (l)
            0:       return 32'h3000_0000;
            1:       return 32'hC000_0000;
            default: return 32'(a);
        endcase
`else
        case (l)
            0:       return 32'(a);
            1:       return 32'(-a);
            default: return 32'(a << 8);
        endcase
`endif
    endfunction

    // Value each lane must carry on the output port.
    function automatic logic [BW-1:0] exp_lane(input int l, input int a);
`ifdef T_READER_RESCALE_EN
        case (l)
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            default: return 32'(4 * a);
        endcase
`else
        return mem_lane(l, a);
`endif
    endfunction

    // BRAM model: address registered twice, data presented READ_LATENCY after enable.
    logic [AW-1:0] rd_a1 = '0;
    logic [AW-1:0] rd_a2 = '0;
    always @(posedge clk_in) begin
        if (bram_en_out) rd_a1 <= bram_addr_out;
        rd_a2 <= rd_a1;
    end
    assign bram_data_0_in = mem_lane(0, int'(rd_a2));
    assign bram_data_1_in = mem_lane(1, int'(rd_a2));
    assign bram_data_2_in = mem_lane(2, int'(rd_a2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"},    bram_en_out, 0);
        check({tag, "_addr"},  bram_addr_out, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_d0"},    out_data_0, 0);
        check({tag, "_d1"},    out_data_1, 0);
        check({tag, "_d2"},    out_data_2, 0);
        check({tag, "_idx"},   out_index, 0);
        check({tag, "_last"},  out_last, 0);
        check({tag, "_busy"},  busy_out, 0);
        check({tag, "_done"},  done_out, 0);
    endtask

    // One transfer. pat: 0 ready high, 1 ready 1,0,0,1, 2 ready low 50 cycles,
    // 3 ready high with extra start pulses. abort_words>0 returns early.
    task automatic run_stream(input int pat, input int abort_words);
        int   issues = 0;
        int   words = 0;
        int   dones = 0;
        int   first_valid = -1;
        int   last_hs = -1;
        int   bubbles = 0;
        int   max_out = 0;
        int   done_cyc = -1;
        logic prev_stall = 1'b0;
        logic [AW-1:0] prev_idx = '0;
        logic [BW-1:0] p0 = '0;
        logic [BW-1:0] p1 = '0;
        logic [BW-1:0] p2 = '0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_in);
            start_in = (c == 0) || (pat == 3 && (c == 10 || c == 60));
            case (pat)
                1:       out_ready = ((c % 4) == 0) || ((c % 4) == 3);
                2:       out_ready = (c >= 50);
                default: out_ready = 1'b1;
            endcase
            if (c == 0) check("busy_before_start", busy_out, 0);
            if (c == 1) begin
                check("first_issue_en", bram_en_out, 1);
                check("first_issue_addr", bram_addr_out, 0);
                check("busy_after_start", busy_out, 1);
            end
            if (pat == 3 && c == 10) check("busy_at_restart", busy_out, 1);
            if (bram_en_out) begin
                check("issue_addr", bram_addr_out, issues);
                issues++;
            end
            if (issues - words > max_out) max_out = issues - words;
            if (pat == 2 && c == 49) check("issues_while_stalled", issues, 4);
            if (out_valid && first_valid < 0) begin
                first_valid = c;
                check("first_valid_cycle", c, 4);
            end
            if (first_valid >= 0 && last_hs < 0 && !out_valid) bubbles++;
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_idx", out_index, prev_idx);
                check("stall_d0", out_data_0, p0);
                check("stall_d1", out_data_1, p1);
                check("stall_d2", out_data_2, p2);
            end
            if (out_valid && out_ready) begin
                check("word_idx", out_index, words);
                check("word_d0", out_data_0, exp_lane(0, words));
                check("word_d1", out_data_1, exp_lane(1, words));
                check("word_d2", out_data_2, exp_lane(2, words));
                check("word_last", out_last, (words == N - 1));
`ifndef T_READER_RESCALE_EN
                if (pat == 0 && words == 7) begin
                    check("word7_d0", out_data_0, 32'd7);
                    check("word7_d1", out_data_1, 32'hFFFF_FFF9);
                    check("word7_d2", out_data_2, 32'd1792);
                end
`endif
                if (words == N - 1) last_hs = c;
                words++;
            end
            prev_stall = out_valid && !out_ready;
            prev_idx   = out_index;
            p0 = out_data_0;
            p1 = out_data_1;
            p2 = out_data_2;
            if (abort_words > 0 && words == abort_words) return;
            if (done_out) begin
                dones++;
                check("done_cycle", c, last_hs + 1);
                check("busy_at_done", busy_out, 0);
                done_cyc = c;
                break;
            end
        end
        start_in = 1'b0;
        check("transfer_completed", (done_cyc >= 0), 1);
        check("word_count", words, N);
        check("issue_count", issues, N);
        check("done_count", dones, 1);
        check("outstanding_within_fifo", (max_out <= 4), 1);
        if (pat == 0) check("bubbles", bubbles, 0);
        if (pat == 3) begin
            for (int t = 0; t < 4; t++) begin
                @(negedge clk_in);
                check("tail_valid", out_valid, 0);
                check("tail_en", bram_en_out, 0);
                check("tail_done", done_out, 0);
            end
        end
    endtask

    initial begin
        rst_in    = 1'b1;
        start_in  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        check_all_zero("reset");
        rst_in = 1'b0;
        @(negedge clk_in);

        run_stream(0, 0);
        run_stream(1, 0);
        run_stream(2, 0);
        run_stream(3, 0);

        // Reset in the middle of a transfer, mid-cycle.
        run_stream(0, 80);
        #7 rst_in = 1'b1;
        #1 check_all_zero("midreset");
        start_in  = 1'b0;
        for (int t = 0; t < 3; t++) @(negedge clk_in);
        check_all_zero("midreset_hold");
        rst_in = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk_in);
            check("post_reset_valid", out_valid, 0);
            check("post_reset_en", bram_en_out, 0);
        end
        run_stream(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
